// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, mid-bit sampling, one-cycle po_flag/frame_err strobes
// Optional: define UART_RX_MAJORITY_VOTE_EN for 2-of-3 voting around the mid-bit sample.
module uart_rx #(
  parameter int CLK_FRE   = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err
);

  localparam int CNT_BAUD_MAX = CLK_FRE / BAUD_RATE;
  localparam int CNT_HALF     = CNT_BAUD_MAX / 2;
  localparam logic [15:0] CNT_LAST = 16'(CNT_BAUD_MAX - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [15:0] CNT_DECIDE = 16'(CNT_HALF + 1);
`else
  localparam logic [15:0] CNT_DECIDE = 16'(CNT_HALF);
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic        rx_s1_q, rx_s1_d;
  logic        rx_s2_q, rx_s2_d;
  logic        rx_s3_q, rx_s3_d;
  logic [15:0] cnt_baud_q, cnt_baud_d;
  logic [2:0]  cnt_bit_q, cnt_bit_d;
  logic        bits_done_q, bits_done_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  po_data_q, po_data_d;
  logic        po_flag_q, po_flag_d;
  logic        frame_err_q, frame_err_d;

  logic        fall_edge;
  logic        decide;
  logic        wrap;
  logic        bit_val;

  assign fall_edge = rx_s3_q & ~rx_s2_q;
  assign decide    = (cnt_baud_q == CNT_DECIDE);
  assign wrap      = (cnt_baud_q == CNT_LAST);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic vote_a_q, vote_a_d;
  logic vote_b_q, vote_b_d;

  // Earlier two samples are held; the third is the live rx_s2 at decision time.
  always_comb begin
    vote_a_d = vote_a_q;
    vote_b_d = vote_b_q;
    if (cnt_baud_q == 16'(CNT_HALF - 1)) vote_a_d = rx_s2_q;
    if (cnt_baud_q == 16'(CNT_HALF))     vote_b_d = rx_s2_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vote_a_q <= 1'b1;
      vote_b_q <= 1'b1;
    end else begin
      vote_a_q <= vote_a_d;
      vote_b_q <= vote_b_d;
    end
  end

  assign bit_val = (vote_a_q & vote_b_q) | (vote_a_q & rx_s2_q) | (vote_b_q & rx_s2_q);
`else
  assign bit_val = rx_s2_q;
`endif

  always_comb begin
    rx_s1_d     = rx;
    rx_s2_d     = rx_s1_q;
    rx_s3_d     = rx_s2_q;
    state_d     = state_q;
    cnt_baud_d  = 16'd0;
    cnt_bit_d   = cnt_bit_q;
    bits_done_d = bits_done_q;
    shift_d     = shift_q;
    po_data_d   = po_data_q;
    po_flag_d   = 1'b0;
    frame_err_d = 1'b0;

    if (state_q != IDLE) begin
      cnt_baud_d = wrap ? 16'd0 : cnt_baud_q + 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        cnt_bit_d   = 3'd0;
        bits_done_d = 1'b0;
        if (fall_edge) state_d = START;
      end
      START: begin
        if (decide && bit_val) begin
          state_d    = IDLE;
          cnt_baud_d = 16'd0;
        end else if (wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (decide) begin
          shift_d[cnt_bit_q] = bit_val;
          cnt_bit_d          = cnt_bit_q + 3'd1;
          if (cnt_bit_q == 3'd7) bits_done_d = 1'b1;
        end
        if (wrap && bits_done_q) state_d = STOP;
      end
      STOP: begin
        // Leave at mid-stop-bit so a start edge right after the stop bit is seen.
        if (decide) begin
          state_d    = IDLE;
          cnt_baud_d = 16'd0;
          if (bit_val) begin
            po_data_d = shift_q;
            po_flag_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_baud_q  <= 16'd0;
      cnt_bit_q   <= 3'd0;
      bits_done_q <= 1'b0;
      shift_q     <= 8'h00;
      po_data_q   <= 8'h00;
      po_flag_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_s3_q     <= rx_s3_d;
      state_q     <= state_d;
      cnt_baud_q  <= cnt_baud_d;
      cnt_bit_q   <= cnt_bit_d;
      bits_done_q <= bits_done_d;
      shift_q     <= shift_d;
      po_data_q   <= po_data_d;
      po_flag_q   <= po_flag_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign po_data   = po_data_q;
  assign po_flag   = po_flag_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at default 50 MHz / 115200 baud
module tb_uart_rx;

  localparam int BIT   = 434;
  localparam int FRAME = 10 * BIT;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int EXP_LAT = 4127;
  localparam logic [7:0] EXP_SPIKE = 8'h00;
`else
  localparam int EXP_LAT = 4126;
  localparam logic [7:0] EXP_SPIKE = 8'h04;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] po_data;
  logic       po_flag;
  logic       frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int         flag_cyc_q[$];
  logic [7:0] flag_data_q[$];
  int         ferr_n = 0;
  int         both_n = 0;

  uart_rx dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .rx       (rx),
    .po_data  (po_data),
    .po_flag  (po_flag),
    .frame_err(frame_err)
  );

  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (po_flag) begin
      flag_cyc_q.push_back(cyc);
      flag_data_q.push_back(po_data);
    end
    if (frame_err) ferr_n++;
    if (po_flag && frame_err) both_n++;
  end

  task automatic clear_mon();
    flag_cyc_q.delete();
    flag_data_q.delete();
    ferr_n = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Drives one frame cycle by cycle; spike_idx forces rx high for that single cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int spike_idx, input int n_cyc);
    for (int i = 0; i < n_cyc; i++) begin
      int k;
      k = i / BIT;
      if (k == 0)      rx = 1'b0;
      else if (k == 9) rx = stop_bit;
      else             rx = b[k-1];
      if (i == spike_idx) rx = 1'b1;
      tick(1);
    end
    rx = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    tick(3);
    n_tests++;
    if (po_data !== 8'h00) begin n_fail++; $display("FAIL reset_po_data got %h want 00", po_data); end
    n_tests++;
    if (po_flag !== 1'b0) begin n_fail++; $display("FAIL reset_po_flag got %b want 0", po_flag); end
    n_tests++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    sys_rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_single_byte();
    int t0;
    clear_mon();
    t0 = cyc;
    send_frame(8'h55, 1'b1, -1, FRAME);
    tick(20);
    n_tests++;
    if (flag_cyc_q.size() != 1) begin n_fail++; $display("FAIL single_flag_count got %0d want 1", flag_cyc_q.size()); end
    else begin
      n_tests++;
      if (flag_data_q[0] !== 8'h55) begin n_fail++; $display("FAIL single_data got %h want 55", flag_data_q[0]); end
      n_tests++;
      if ((flag_cyc_q[0] - t0) < EXP_LAT - 1 || (flag_cyc_q[0] - t0) > EXP_LAT + 1) begin
        n_fail++; $display("FAIL single_latency got %0d want %0d+-1", flag_cyc_q[0] - t0, EXP_LAT);
      end
    end
    n_tests++;
    if (ferr_n != 0) begin n_fail++; $display("FAIL single_frame_err got %0d pulses want 0", ferr_n); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(8'hA5, 1'b1, -1, FRAME);
    send_frame(8'h3C, 1'b1, -1, FRAME);
    tick(20);
    n_tests++;
    if (flag_cyc_q.size() != 2) begin n_fail++; $display("FAIL b2b_flag_count got %0d want 2", flag_cyc_q.size()); end
    else begin
      n_tests++;
      if (flag_data_q[0] !== 8'hA5) begin n_fail++; $display("FAIL b2b_data0 got %h want a5", flag_data_q[0]); end
      n_tests++;
      if (flag_data_q[1] !== 8'h3C) begin n_fail++; $display("FAIL b2b_data1 got %h want 3c", flag_data_q[1]); end
      n_tests++;
      if ((flag_cyc_q[1] - flag_cyc_q[0]) < FRAME - 1 || (flag_cyc_q[1] - flag_cyc_q[0]) > FRAME + 1) begin
        n_fail++; $display("FAIL b2b_spacing got %0d want %0d+-1", flag_cyc_q[1] - flag_cyc_q[0], FRAME);
      end
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0;
    tick(100);
    rx = 1'b1;
    tick(2 * BIT);
    n_tests++;
    if (flag_cyc_q.size() != 0) begin n_fail++; $display("FAIL glitch_flag got %0d pulses want 0", flag_cyc_q.size()); end
    n_tests++;
    if (ferr_n != 0) begin n_fail++; $display("FAIL glitch_frame_err got %0d pulses want 0", ferr_n); end
    send_frame(8'h0F, 1'b1, -1, FRAME);
    tick(20);
    n_tests++;
    if (flag_cyc_q.size() != 1 || po_data !== 8'h0F) begin
      n_fail++; $display("FAIL glitch_next_frame got %0d pulses data %h want 1 pulse data 0f", flag_cyc_q.size(), po_data);
    end
  endtask

  task automatic test_frame_error();
    clear_mon();
    send_frame(8'h12, 1'b1, -1, FRAME);
    tick(BIT);
    n_tests++;
    if (flag_cyc_q.size() != 1 || po_data !== 8'h12) begin
      n_fail++; $display("FAIL ferr_prior_frame got %0d pulses data %h want 1 pulse data 12", flag_cyc_q.size(), po_data);
    end
    send_frame(8'hFF, 1'b0, -1, FRAME);
    tick(2 * BIT);
    n_tests++;
    if (ferr_n != 1) begin n_fail++; $display("FAIL ferr_pulse got %0d pulses want 1", ferr_n); end
    n_tests++;
    if (flag_cyc_q.size() != 1) begin n_fail++; $display("FAIL ferr_flag got %0d total pulses want 1", flag_cyc_q.size()); end
    n_tests++;
    if (po_data !== 8'h12) begin n_fail++; $display("FAIL ferr_po_data got %h want 12", po_data); end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    send_frame(8'h81, 1'b1, -1, 5 * BIT + BIT / 2);
    sys_rst_n = 1'b0;
    #5;
    n_tests++;
    if (po_data !== 8'h00 || po_flag !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs got data %h flag %b ferr %b want 00 0 0", po_data, po_flag, frame_err);
    end
    tick(2);
    sys_rst_n = 1'b1;
    tick(2 * BIT);
    n_tests++;
    if (flag_cyc_q.size() != 0 || ferr_n != 0) begin
      n_fail++; $display("FAIL midreset_strobe got flags %0d ferr %0d want 0 0", flag_cyc_q.size(), ferr_n);
    end
    n_tests++;
    if (po_data !== 8'h00) begin n_fail++; $display("FAIL midreset_hold got %h want 00", po_data); end
    send_frame(8'hC3, 1'b1, -1, FRAME);
    tick(20);
    n_tests++;
    if (flag_cyc_q.size() != 1 || po_data !== 8'hC3) begin
      n_fail++; $display("FAIL midreset_next got %0d pulses data %h want 1 pulse data c3", flag_cyc_q.size(), po_data);
    end
  endtask

  // Spike index 1520 lands the one-cycle high exactly on rx_s2 at the CNT_HALF count of bit 2.
  task automatic test_spike();
    clear_mon();
    send_frame(8'h00, 1'b1, 1520, FRAME);
    tick(20);
    n_tests++;
    if (flag_cyc_q.size() != 1 || po_data !== EXP_SPIKE) begin
      n_fail++; $display("FAIL spike_data got %0d pulses data %h want 1 pulse data %h", flag_cyc_q.size(), po_data, EXP_SPIKE);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_spike();
    n_tests++;
    if (both_n != 0) begin n_fail++; $display("FAIL flag_and_ferr_together got %0d want 0", both_n); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's serial transmitter.
- Samples the asynchronous rx line at mid-bit and converts the serial frame to an 8-bit parallel byte.
- Raises a one-cycle po_flag strobe when a byte is valid.
- Sits between the board RX pin and the menu/command logic; shares CLK_FRE/BAUD_RATE parameters with the transmitter so both ends use the same baud.

Parameters:
- CLK_FRE, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- Derived localparam CNT_BAUD_MAX = CLK_FRE/BAUD_RATE (434 at defaults).
- Derived localparam CNT_HALF = CNT_BAUD_MAX/2 (217).

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst_n  input  1  asynchronous reset, active-low.
- rx  input  1  serial input, asynchronous to sys_clk, idle high.
- po_data  output  8  last correctly received byte, LSB first on wire.
- po_flag  output  1  one-cycle strobe; po_data is valid in the same cycle.
- frame_err  output  1  one-cycle strobe when the stop bit is sampled low.

Behaviour:
- Reset (async, sys_rst_n low):
  - po_data=8'h00, po_flag=0, frame_err=0.
  - Synchronizer flops=1, state=IDLE, counters=0.
  - Reset mid-frame aborts the frame with no output strobe.
- Input sync: rx passes through 2 flops (rx_s1, rx_s2) plus a third history flop rx_s3. Falling edge = rx_s3 & ~rx_s2.
- Baud counter: cnt_baud, 16 bits. Counts 0..CNT_BAUD_MAX-1 while state != IDLE, wraps to 0, and is held at 0 in IDLE. CNT_BAUD_MAX must be < 65536.
- Sample point: cnt_baud == CNT_HALF.
- cnt_bit: 0..7 data bit index. Increments at each DATA sample; cleared in IDLE.
- State machine:
  - IDLE: on falling edge, go to START with cnt_baud=0. All other rx activity is ignored.
  - START: at the sample point, if rx_s2==1 (glitch/false start), return to IDLE with no strobe. Otherwise go to DATA at the next cnt_baud wrap.
  - DATA: at each sample point, shift rx_s2 into a shift register at bit cnt_bit (LSB first). After bit 7 is sampled, go to STOP at the next wrap.
  - STOP: at the sample point:
    - if rx_s2==1: po_data <= shift register and po_flag=1 for one cycle in the next clock.
    - if rx_s2==0: frame_err=1 for one cycle, po_data unchanged, no po_flag.
    - In both cases return to IDLE immediately (at mid-stop-bit) so a back-to-back start edge is caught.
- Falling edges outside IDLE are ignored. po_flag and frame_err are never high together.
- Latency: po_flag rises 9*CNT_BAUD_MAX + CNT_HALF + 3 cycles (±1) after the rx pin falls (4126 at defaults).
- po_data holds its value until the next good frame.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined: each bit (start, data, stop) is decided by a 2-of-3 majority of rx_s2 sampled at cnt_baud == CNT_HALF-1, CNT_HALF, and CNT_HALF+1. Decisions and state actions occur at CNT_HALF+1, so all latencies are one cycle later.
- Undefined: single sample at CNT_HALF as described above; no vote registers.

Test Plan:
- Byte 8'h55 sent at 115200 baud, stop=1 -> po_data=8'h55, po_flag high exactly 1 cycle, 4126±1 cycles after the start edge; frame_err stays 0.
- Back-to-back 8'hA5 then 8'h3C, each with one stop bit, zero idle gap -> two po_flag pulses 10*434±1 cycles apart; po_data 8'hA5 then 8'h3C.
- rx low for 100 cycles then high (glitch) -> no po_flag, no frame_err; the following 8'h0F frame is received correctly.
- 8'hFF sent with stop bit=0, after a prior good 8'h12 -> frame_err 1-cycle pulse, po_flag 0, po_data stays 8'h12.
- sys_rst_n pulsed low during data bit 4 of a frame, then a clean 8'hC3 sent -> no strobe for the aborted frame, all outputs at reset values, then po_data=8'hC3 with po_flag.
- With UART_RX_MAJORITY_VOTE_EN defined: 8'h00 sent with a 1-cycle high spike on rx exactly at the CNT_HALF sample of bit 2 -> po_data=8'h00. With the macro undefined, the same stimulus -> po_data=8'h04.
